oam_dma: RTL and testbench

OAM DMA engine: the writer side of the PPU sprite attribute memory. A CPU write to the $4014 register triggers it. It halts the CPU, reads 256 bytes from CPU page `{page, 8'h00}..{page, 8'hFF}`, and writes them into OAM through the OAM write port (`addr`/`we`/`data_in`). It sits between the CPU bus arbiter and the OAM, and replaces repeated CPU writes to $2004.

---
 rtl/oam_dma.sv | 87 ++++++++
 tb/tb_oam_dma.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// OAM DMA engine: on a $4014 write, halts the CPU and copies one 256-byte CPU
// page into sprite OAM through the OAM write port, one READ/WRITE pair per byte.
module oam_dma #(
   parameter int OAM_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cpu_clk_en,
   input  logic                 reg_we,
   input  logic [7:0]           reg_data,
   input  logic [OAM_WIDTH-1:0] oam_start,
   output logic [15:0]          mem_addr,
   output logic                 mem_re,
   input  logic [7:0]           mem_rdata,
   output logic [OAM_WIDTH-1:0] oam_addr,
   output logic                 oam_we,
   output logic [7:0]           oam_wdata,
   output logic                 cpu_rdy,
   output logic                 busy
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } state_t;

   state_t               state;
   logic                 parity;
   logic [7:0]           page;
   logic [OAM_WIDTH-1:0] base;
   logic [7:0]           idx;
   logic [7:0]           rd_buf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         parity <= 1'b0;
         page   <= 8'h00;
         base   <= '0;
         idx    <= 8'h00;
         rd_buf <= 8'h00;
      end else if (cpu_clk_en) begin
         parity <= ~parity;
         case (state)
            IDLE: begin
               if (reg_we) begin
                  page  <= reg_data;
                  base  <= oam_start;
                  idx   <= 8'h00;
                  state <= HALT;
               end
            end
            // READ must land on an even CPU cycle; burn one cycle if it would not.
            HALT:  state <= parity ? READ : ALIGN;
            ALIGN: state <= READ;
            READ: begin
               rd_buf <= mem_rdata;
               state  <= WRITE;
            end
            WRITE: begin
               if (idx == 8'hFF) begin
                  state <= IDLE;
               end else begin
                  idx   <= idx + 8'h01;
                  state <= READ;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus-facing outputs are zero unless the matching state owns them.
   always_comb begin
      busy      = (state != IDLE);
      cpu_rdy   = (state == IDLE);
      mem_re    = (state == READ);
      oam_we    = (state == WRITE);
      mem_addr  = mem_re ? {page, idx} : 16'h0000;
      oam_addr  = oam_we ? (base + OAM_WIDTH'(idx)) : '0;
      oam_wdata = oam_we ? rd_buf : 8'h00;
   end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: stimulus queues expected OAM writes, a negedge
// monitor pops and compares them and tracks read pages and halt length.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_clk_en = 1'b0;
   logic        reg_we = 1'b0;
   logic [7:0]  reg_data = 8'h00;
   logic [7:0]  oam_start = 8'h00;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic [7:0]  mem_rdata;
   logic [7:0]  oam_addr;
   logic        oam_we;
   logic [7:0]  oam_wdata;
   logic        cpu_rdy;
   logic        busy;

   oam_dma #(.OAM_WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .cpu_clk_en(cpu_clk_en),
      .reg_we(reg_we), .reg_data(reg_data), .oam_start(oam_start),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
      .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata),
      .cpu_rdy(cpu_rdy), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
   wr_t        exp_q[$];
   logic [7:0] mem [0:65535];
   logic [7:0] oam [0:255];
   int         checks = 0, errors = 0;
   int         halt_cnt = 0, rd_cnt = 0, wr_cnt = 0;
   logic [7:0] exp_page = 8'h00;
   bit         tb_par = 1'b0;
   bit         gap_mode = 1'b0;

   assign mem_rdata = mem[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: outputs sampled mid-cycle together with this cycle's enable.
   always @(negedge clk) begin
      if (rst_n && cpu_clk_en) begin
         if (!cpu_rdy) halt_cnt++;
         if (mem_re) begin
            rd_cnt++;
            check("read_page", mem_addr[15:8], exp_page);
         end
         if (oam_we) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0h data %0h expected none", oam_addr, oam_wdata);
            end else begin
               wr_t e;
               e = exp_q.pop_front();
               check("oam_addr", oam_addr, e.a);
               check("oam_wdata", oam_wdata, e.d);
            end
            oam[oam_addr] = oam_wdata;
            wr_cnt++;
         end
      end
   end

   task automatic cyc(input bit en);
      cpu_clk_en = en;
      @(posedge clk);
      if (en && rst_n) tb_par = ~tb_par;
      #1;
   endtask

   task automatic next_cyc();
      cyc(gap_mode ? ($urandom_range(0, 3) == 0) : 1'b1);
   endtask

   // Trigger so that the HALT cycle does (align=1) or does not need ALIGN.
   task automatic trig(input logic [7:0] pg, input logic [7:0] start, input bit align);
      int n = 0;
      while (tb_par != align && n < 4) begin cyc(1'b1); n++; end
      for (int i = 0; i < 256; i++) begin
         wr_t e;
         e.a = start + 8'(i);
         e.d = mem[{pg, 8'(i)}];
         exp_q.push_back(e);
      end
      exp_page  = pg;
      halt_cnt  = 0;
      rd_cnt    = 0;
      wr_cnt    = 0;
      reg_we    = 1'b1;
      reg_data  = pg;
      oam_start = start;
      cyc(1'b1);
      reg_we    = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_halt);
      int n = 0;
      while (busy && n < 5000) begin next_cyc(); n++; end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got busy expected idle", name);
      end
      check({name, "_halt_len"}, halt_cnt, exp_halt);
      check({name, "_reads"}, rd_cnt, 256);
      check({name, "_queue_left"}, exp_q.size(), 0);
   endtask

   task automatic check_oam_identity(input string name);
      int bad = 0;
      for (int i = 0; i < 256; i++) if (oam[i] !== 8'(i)) bad++;
      check(name, bad, 0);
   endtask

   task automatic clear_oam();
      for (int i = 0; i < 256; i++) oam[i] = 8'h00;
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem[16'h0200 + i] = 8'(i);
         mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
         mem[16'h0700 + i] = 8'hEE;
      end
      clear_oam();

      // Reset state
      #12;
      check("rst_cpu_rdy", cpu_rdy, 1);
      check("rst_busy", busy, 0);
      check("rst_mem_re", mem_re, 0);
      check("rst_oam_we", oam_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_oam_addr", oam_addr, 0);
      check("rst_oam_wdata", oam_wdata, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      tb_par = 1'b0;
      cyc(1'b1);

      // Trigger without enable is ignored
      reg_we = 1'b1; reg_data = 8'h02;
      cyc(1'b0); cyc(1'b0);
      reg_we = 1'b0;
      cyc(1'b1);
      check("no_en_trigger_busy", busy, 0);

      // Aligned: HALT on parity 1, no ALIGN
      trig(8'h02, 8'h00, 1'b0);
      check("trig_cpu_rdy_fall", cpu_rdy, 0);
      wait_done("aligned", 513);
      check_oam_identity("aligned_oam");
      check("idle_mem_addr", mem_addr, 0);

      // Misaligned: ALIGN inserted
      clear_oam();
      trig(8'h02, 8'h00, 1'b1);
      wait_done("misaligned", 514);
      check_oam_identity("misaligned_oam");

      // Address wrap from FC
      trig(8'h03, 8'hFC, 1'b0);
      wait_done("wrap", 513);
      check("wrap_oam_fc", oam[8'hFC], 8'hA5);
      check("wrap_oam_fb", oam[8'hFB], 8'hFF ^ 8'hA5);

      // Retrigger with page 7 while busy on page 2
      trig(8'h02, 8'h00, 1'b1);
      begin
         int n = 0;
         while (wr_cnt < 40 && n < 200) begin cyc(1'b1); n++; end
      end
      reg_we = 1'b1; reg_data = 8'h07;
      cyc(1'b1);
      reg_we = 1'b0;
      wait_done("retrig", 514);
      check_oam_identity("retrig_oam");

      // ~25% enable duty
      clear_oam();
      gap_mode = 1'b1;
      trig(8'h02, 8'h00, 1'b0);
      wait_done("gaps", 513);
      check_oam_identity("gaps_oam");
      trig(8'h02, 8'h00, 1'b1);
      wait_done("gaps_align", 514);
      gap_mode = 1'b0;

      // Reset after 100 bytes; seed OAM with the wrap pattern first
      trig(8'h03, 8'hFC, 1'b0);
      wait_done("preload", 513);
      trig(8'h02, 8'h00, 1'b0);
      begin
         int n = 0;
         while (wr_cnt < 100 && n < 400) begin cyc(1'b1); n++; end
      end
      rst_n = 1'b0;
      #1;
      check("midrst_cpu_rdy", cpu_rdy, 1);
      check("midrst_oam_we", oam_we, 0);
      check("midrst_busy", busy, 0);
      exp_q.delete();
      tb_par = 1'b0;
      cyc(1'b1);
      rst_n = 1'b1;
      cyc(1'b1); cyc(1'b1);
      check("midrst_writes", wr_cnt, 100);
      begin
         int bad = 0;
         for (int i = 100; i < 256; i++)
            if (oam[i] !== (8'(i + 4) ^ 8'hA5)) bad++;
         check("midrst_untouched", bad, 0);
      end
      trig(8'h02, 8'h00, 1'b1);
      wait_done("post_rst", 514);
      check_oam_identity("post_rst_oam");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
